// File: rtl/io_port_pkg.sv
// Shared defaults and width helpers for the buffered CPU I/O port.
// Imported by the FIFO, the bus interface and the io_port top.
package io_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 4;

  function automatic int ptr_w(int depth);
    return $clog2(depth);
  endfunction

  localparam int PTR_W_DEFAULT = ptr_w(DEPTH_DEFAULT);

endpackage

// File: rtl/io_port_if.sv
// Bus bundle between the io_port and its CPU/external neighbours.
// master drives CPU and producer/consumer inputs; slave is io_port.
interface io_port_if
  import io_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             cpu_wr_en;
  logic [WIDTH-1:0] cpu_wr_data;
  logic             cpu_rd_en;
  logic [WIDTH-1:0] cpu_rd_data;
  logic             cpu_in_valid;
  logic             cpu_out_full;
  logic [WIDTH-1:0] ext_out_data;
  logic             ext_out_valid;
  logic             ext_out_ready;
  logic [WIDTH-1:0] ext_in_data;
  logic             ext_in_valid;
  logic             ext_in_ready;
  logic             clear_errors;
  logic             overflow;
  logic             underflow;

  modport master (
    output cpu_wr_en, cpu_wr_data,
    output cpu_rd_en,
    output ext_out_ready,
    output ext_in_data, ext_in_valid,
    output clear_errors,
    input  cpu_rd_data, cpu_in_valid,
    input  cpu_out_full,
    input  ext_out_data, ext_out_valid,
    input  ext_in_ready,
    input  overflow, underflow
  );

  modport slave (
    input  cpu_wr_en, cpu_wr_data,
    input  cpu_rd_en,
    input  ext_out_ready,
    input  ext_in_data, ext_in_valid,
    input  clear_errors,
    output cpu_rd_data, cpu_in_valid,
    output cpu_out_full,
    output ext_out_data, ext_out_valid,
    output ext_in_ready,
    output overflow, underflow
  );

endinterface

// File: rtl/io_port_fifo.sv
// First-word-fall-through FIFO; head reads 0 when empty.
// Ports: clock, reset (async low), push/push_data, pop, head_data, empty, full, count.
module io_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Caller guarantees push only when not full (or popping)
  // and pop only when not empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_port.sv
// Buffered CPU I/O port: output FIFO to an external consumer, input FIFO from a producer.
// Ports: clock, reset (async low), bus (io_port_if.slave) with sticky overflow/underflow.
module io_port
  import io_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input logic      clock,
  input logic      reset,
  io_port_if.slave bus
);

  localparam int CW = ptr_w(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          out_push, out_pop;
  logic          out_empty, out_full;
  logic [CW-1:0] out_count;
  logic          in_push, in_pop;
  logic          in_empty, in_full;
  logic [CW-1:0] in_count;
  logic          ovf_set, udf_set;

  // A write into a full output FIFO still lands if the
  // consumer frees a slot on the same edge.
  assign out_pop  = !out_empty && bus.ext_out_ready;
  assign out_push = bus.cpu_wr_en && (!out_full || out_pop);
  assign ovf_set  = bus.cpu_wr_en && out_full && !out_pop;

  assign in_push = bus.ext_in_valid && !in_full;
  assign in_pop  = bus.cpu_rd_en && !in_empty;
  assign udf_set = bus.cpu_rd_en && in_empty;

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (out_push),
    .push_data (bus.cpu_wr_data),
    .pop       (out_pop),
    .head_data (bus.ext_out_data),
    .empty     (out_empty),
    .full      (out_full),
    .count     (out_count)
  );

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_push),
    .push_data (bus.ext_in_data),
    .pop       (in_pop),
    .head_data (bus.cpu_rd_data),
    .empty     (in_empty),
    .full      (in_full),
    .count     (in_count)
  );

  // Set has priority over clear so a fresh error is never lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (ovf_set)
        bus.overflow <= 1'b1;
      else if (bus.clear_errors)
        bus.overflow <= 1'b0;
      if (udf_set)
        bus.underflow <= 1'b1;
      else if (bus.clear_errors)
        bus.underflow <= 1'b0;
    end
  end

  assign bus.ext_out_valid = !out_empty;
  assign bus.cpu_out_full  = out_full;
  assign bus.cpu_in_valid  = !in_empty;
  assign bus.ext_in_ready  = !in_full;

  a_out_cnt: assert property (
    @(posedge clock) disable iff (!reset)
    out_count <= FULL_CNT
  );

  a_in_cnt: assert property (
    @(posedge clock) disable iff (!reset)
    in_count <= FULL_CNT
  );

endmodule

// File: tb/tb_io_port.sv
// Directed self-checking bench for io_port with DEPTH=4.
// Linear step sequence; each check is an immediate assertion.
module tb_io_port;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  io_port_if #(.WIDTH(8)) bus ();

  io_port #(.WIDTH(8), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.cpu_wr_en     = 1'b0;
    bus.cpu_wr_data   = 8'h00;
    bus.cpu_rd_en     = 1'b0;
    bus.ext_out_ready = 1'b0;
    bus.ext_in_data   = 8'h00;
    bus.ext_in_valid  = 1'b0;
    bus.clear_errors  = 1'b0;
  endtask

  task automatic cpu_write(logic [7:0] d);
    bus.cpu_wr_en   = 1'b1;
    bus.cpu_wr_data = d;
    tick();
    bus.cpu_wr_en   = 1'b0;
  endtask

  task automatic ext_drain(logic [7:0] exp, string tag);
    chk({tag, "_valid"}, 8'(bus.ext_out_valid), 8'h01);
    chk({tag, "_data"}, bus.ext_out_data, exp);
    bus.ext_out_ready = 1'b1;
    tick();
    bus.ext_out_ready = 1'b0;
  endtask

  task automatic ext_push(logic [7:0] d);
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = d;
    tick();
    bus.ext_in_valid = 1'b0;
  endtask

  task automatic cpu_read(logic [7:0] exp, string tag);
    chk({tag, "_valid"}, 8'(bus.cpu_in_valid), 8'h01);
    chk({tag, "_data"}, bus.cpu_rd_data, exp);
    bus.cpu_rd_en = 1'b1;
    tick();
    bus.cpu_rd_en = 1'b0;
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_in_valid"}, 8'(bus.cpu_in_valid), 8'h00);
    chk({tag, "_out_valid"}, 8'(bus.ext_out_valid), 8'h00);
    chk({tag, "_out_full"}, 8'(bus.cpu_out_full), 8'h00);
    chk({tag, "_rd_data"}, bus.cpu_rd_data, 8'h00);
    chk({tag, "_out_data"}, bus.ext_out_data, 8'h00);
    chk({tag, "_in_ready"}, 8'(bus.ext_in_ready), 8'h01);
  endtask

  initial begin
    idle();
    #12;
    chk_idle("rst");
    chk("rst_ovf", 8'(bus.overflow), 8'h00);
    chk("rst_udf", 8'(bus.underflow), 8'h00);
    tick();
    reset = 1'b1;
    tick();

    // Basic writes with the consumer stalled.
    cpu_write(8'h11);
    chk("w1_valid", 8'(bus.ext_out_valid), 8'h01);
    chk("w1_data", bus.ext_out_data, 8'h11);
    cpu_write(8'h22);
    cpu_write(8'h33);
    chk("w3_data", bus.ext_out_data, 8'h11);
    chk("w3_full", 8'(bus.cpu_out_full), 8'h00);
    ext_drain(8'h11, "d11");
    ext_drain(8'h22, "d22");
    ext_drain(8'h33, "d33");
    chk("d_empty", 8'(bus.ext_out_valid), 8'h00);
    chk("d_zero", bus.ext_out_data, 8'h00);

    // Overflow: a fifth write with no pop is dropped.
    for (int i = 0; i < 4; i++) cpu_write(8'hA0 + 8'(i));
    chk("f_full", 8'(bus.cpu_out_full), 8'h01);
    cpu_write(8'hFF);
    chk("ovf_set", 8'(bus.overflow), 8'h01);
    chk("ovf_full", 8'(bus.cpu_out_full), 8'h01);
    for (int i = 0; i < 4; i++) ext_drain(8'hA0 + 8'(i), "ovd");
    chk("ovd_empty", 8'(bus.ext_out_valid), 8'h00);
    bus.clear_errors = 1'b1;
    tick();
    bus.clear_errors = 1'b0;
    chk("ovf_clr", 8'(bus.overflow), 8'h00);

    // Write into a full FIFO while the consumer pops.
    for (int i = 0; i < 4; i++) cpu_write(8'hA0 + 8'(i));
    bus.cpu_wr_en     = 1'b1;
    bus.cpu_wr_data   = 8'h55;
    bus.ext_out_ready = 1'b1;
    tick();
    bus.cpu_wr_en     = 1'b0;
    bus.ext_out_ready = 1'b0;
    chk("pp_full", 8'(bus.cpu_out_full), 8'h01);
    chk("pp_ovf", 8'(bus.overflow), 8'h00);
    ext_drain(8'hA1, "pp1");
    ext_drain(8'hA2, "pp2");
    ext_drain(8'hA3, "pp3");
    ext_drain(8'h55, "pp4");
    chk("pp_empty", 8'(bus.ext_out_valid), 8'h00);
    chk("pp_ovf2", 8'(bus.overflow), 8'h00);

    // Producer fills the input FIFO.
    for (int i = 1; i <= 3; i++) ext_push(8'(i));
    chk("ip3_ready", 8'(bus.ext_in_ready), 8'h01);
    ext_push(8'h04);
    chk("ip4_ready", 8'(bus.ext_in_ready), 8'h00);
    chk("ip4_head", bus.cpu_rd_data, 8'h01);
    // Offered while full: must not be taken.
    ext_push(8'h05);
    chk("ip5_ready", 8'(bus.ext_in_ready), 8'h00);
    chk("ip5_head", bus.cpu_rd_data, 8'h01);
    cpu_read(8'h01, "r1");
    chk("r1_ready", 8'(bus.ext_in_ready), 8'h01);
    cpu_read(8'h02, "r2");
    cpu_read(8'h03, "r3");
    cpu_read(8'h04, "r4");
    chk("r_empty", 8'(bus.cpu_in_valid), 8'h00);
    chk("r_zero", bus.cpu_rd_data, 8'h00);
    ext_push(8'h05);
    ext_push(8'h06);
    // Push and pop together: count holds, order kept.
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = 8'h07;
    cpu_read(8'h05, "r5");
    bus.ext_in_valid = 1'b0;
    cpu_read(8'h06, "r6");
    cpu_read(8'h07, "r7");
    chk("r7_empty", 8'(bus.cpu_in_valid), 8'h00);
    chk("r_udf0", 8'(bus.underflow), 8'h00);

    // Underflow and clear priority.
    bus.cpu_rd_en = 1'b1;
    tick();
    bus.cpu_rd_en = 1'b0;
    chk("u_data", bus.cpu_rd_data, 8'h00);
    chk("u_set", 8'(bus.underflow), 8'h01);
    chk("u_valid", 8'(bus.cpu_in_valid), 8'h00);
    bus.clear_errors = 1'b1;
    tick();
    chk("u_clr", 8'(bus.underflow), 8'h00);
    bus.cpu_rd_en = 1'b1;
    tick();
    bus.cpu_rd_en    = 1'b0;
    bus.clear_errors = 1'b0;
    chk("u_setwin", 8'(bus.underflow), 8'h01);
    tick();
    chk("u_hold", 8'(bus.underflow), 8'h01);

    // Asynchronous reset with two entries in each FIFO.
    cpu_write(8'h71);
    cpu_write(8'h72);
    ext_push(8'h81);
    ext_push(8'h82);
    chk("ar_out_v", 8'(bus.ext_out_valid), 8'h01);
    chk("ar_in_d", bus.cpu_rd_data, 8'h81);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("ar");
    chk("ar_udf", 8'(bus.underflow), 8'h00);
    tick();
    reset = 1'b1;
    tick();
    chk_idle("ar_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
